// File: rtl/sweep_scheduler.sv
// sweep_scheduler
//   Sequences the impedance-sweep measurement path. For each of 2^avg_log2
//   sweeps it raises mp_start, accepts one magnitude (valid_m/modulo) and one
//   phase (valid_p/phase) result per point, waits for the path to finish and
//   release, then repeats. Results are summed per point. The system bus reads
//   them back divided by the sweep count.
//
// Ports
//   clk125, areset_n         clock, asynchronous active-low reset
//   cmd_start, cmd_abort     1-cycle command pulses from the register bank
//   num_points, avg_log2     run configuration, latched at cmd_start
//   mp_start / mp_fin        level handshake with the measurement path
//   valid_m, modulo          unsigned magnitude result strobe
//   valid_p, phase           signed phase result strobe
//   rd_addr, rd_sel, rd_data averaged readback, 1-cycle latency
//   busy, done, err_timeout, err_overflow, sweep_idx   status
module sweep_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                  clk125,
  input  logic                  areset_n,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  input  logic [ADDR_WIDTH-1:0] num_points,
  input  logic [1:0]            avg_log2,
  output logic                  mp_start,
  input  logic                  mp_fin,
  input  logic                  valid_m,
  input  logic [DATA_WIDTH-1:0] modulo,
  input  logic                  valid_p,
  input  logic [DATA_WIDTH-1:0] phase,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_sel,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  err_overflow,
  output logic [2:0]            sweep_idx
);

  // Three guard bits hold the sum of up to eight sweeps without wrapping.
  localparam int ACC_W = DATA_WIDTH + 3;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] np_q, np_d;
  logic [1:0]            avg_q, avg_d;
  logic [2:0]            sweep_q, sweep_d;
  logic [ADDR_WIDTH-1:0] m_ptr_q, m_ptr_d;
  logic [ADDR_WIDTH-1:0] p_ptr_q, p_ptr_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  mp_start_q, mp_start_d;
  logic                  err_to_q, err_to_d;
  logic                  err_ov_q, err_ov_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic        [ACC_W-1:0] acc_m_mem [DEPTH];
  logic signed [ACC_W-1:0] acc_p_mem [DEPTH];

  logic                    acc_m_wr, acc_p_wr;
  logic        [ACC_W-1:0] acc_m_wdata;
  logic signed [ACC_W-1:0] acc_p_wdata;
  logic                    strobe_win, counting;
  logic [2:0]              last_sweep;

  function automatic logic [DATA_WIDTH-1:0] avg_mag(input logic [ACC_W-1:0] a,
                                                    input logic [1:0] s);
    return DATA_WIDTH'(a >> s);
  endfunction

  // Arithmetic shift: negative sums round toward minus infinity.
  function automatic logic [DATA_WIDTH-1:0] avg_phase(input logic signed [ACC_W-1:0] a,
                                                      input logic [1:0] s);
    return DATA_WIDTH'(a >>> s);
  endfunction

  assign last_sweep = 3'((4'd1 << avg_q) - 4'd1);
  assign strobe_win = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign counting   = (state_q == S_ARM) || (state_q == S_RUN) ||
                      (state_q == S_DRAIN) || (state_q == S_RELEASE);

  // The first sweep overwrites, so stale sums from a previous run never leak in.
  always_comb begin
    acc_m_wr    = strobe_win && valid_m && (m_ptr_q < np_q);
    acc_p_wr    = strobe_win && valid_p && (p_ptr_q < np_q);
    acc_m_wdata = ((sweep_q == 3'd0) ? '0 : acc_m_mem[m_ptr_q]) + ACC_W'(modulo);
    acc_p_wdata = ((sweep_q == 3'd0) ? '0 : acc_p_mem[p_ptr_q]) +
                  {{3{phase[DATA_WIDTH-1]}}, phase};
  end

  always_comb begin
    state_d    = state_q;
    np_d       = np_q;
    avg_d      = avg_q;
    sweep_d    = sweep_q;
    m_ptr_d    = m_ptr_q;
    p_ptr_d    = p_ptr_q;
    mp_start_d = mp_start_q;
    err_to_d   = err_to_q;
    err_ov_d   = err_ov_q;

    if (acc_m_wr) m_ptr_d = m_ptr_q + 1'b1;
    if (acc_p_wr) p_ptr_d = p_ptr_q + 1'b1;
    if (strobe_win && ((valid_m && m_ptr_q == np_q) || (valid_p && p_ptr_q == np_q)))
      err_ov_d = 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (cmd_start && num_points != '0) begin
          np_d       = num_points;
          avg_d      = avg_log2;
          sweep_d    = 3'd0;
          err_to_d   = 1'b0;
          err_ov_d   = 1'b0;
          mp_start_d = 1'b1;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        m_ptr_d = '0;
        p_ptr_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (mp_fin) state_d = S_DRAIN;
      end
      // Results may trail mp_fin; hold until every point has both values.
      S_DRAIN: begin
        if (m_ptr_q == np_q && p_ptr_q == np_q) begin
          mp_start_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!mp_fin) begin
          if (sweep_q == last_sweep) begin
            state_d = S_DONE;
          end else begin
            sweep_d    = sweep_q + 3'd1;
            mp_start_d = 1'b1;
            state_d    = S_ARM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (counting && timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      state_d    = S_ERROR;
      mp_start_d = 1'b0;
      err_to_d   = 1'b1;
    end

    if (cmd_abort) begin
      state_d    = S_IDLE;
      mp_start_d = 1'b0;
      err_to_d   = 1'b0;
      err_ov_d   = 1'b0;
    end
  end

  // Progress (state change or accepted strobe) restarts the watchdog.
  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q || acc_m_wr || acc_p_wr) timer_d = '0;
    else if (counting) timer_d = timer_q + 1'b1;
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_addr < np_q)
      rd_data_d = rd_sel ? avg_phase(acc_p_mem[rd_addr], avg_q)
                         : avg_mag(acc_m_mem[rd_addr], avg_q);
  end

  always_ff @(posedge clk125 or negedge areset_n) begin
    if (!areset_n) begin
      state_q    <= S_IDLE;
      np_q       <= '0;
      avg_q      <= '0;
      sweep_q    <= '0;
      m_ptr_q    <= '0;
      p_ptr_q    <= '0;
      timer_q    <= '0;
      mp_start_q <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      np_q       <= np_d;
      avg_q      <= avg_d;
      sweep_q    <= sweep_d;
      m_ptr_q    <= m_ptr_d;
      p_ptr_q    <= p_ptr_d;
      timer_q    <= timer_d;
      mp_start_q <= mp_start_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk125) begin
    if (acc_m_wr) acc_m_mem[m_ptr_q] <= acc_m_wdata;
    if (acc_p_wr) acc_p_mem[p_ptr_q] <= acc_p_wdata;
  end

  assign mp_start     = mp_start_q;
  assign busy         = counting;
  assign done         = (state_q == S_DONE);
  assign err_timeout  = err_to_q;
  assign err_overflow = err_ov_q;
  assign sweep_idx    = sweep_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
module tb_sweep_scheduler;

  logic        clk125 = 1'b0;
  logic        areset_n;
  logic        cmd_start, cmd_abort;
  logic [7:0]  num_points;
  logic [1:0]  avg_log2;
  logic        mp_start, mp_fin;
  logic        valid_m, valid_p;
  logic [31:0] modulo, phase;
  logic [7:0]  rd_addr;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy, done, err_timeout, err_overflow;
  logic [2:0]  sweep_idx;

  int checks = 0;
  int errors = 0;

  int m_tab [8][4];
  int p_tab [8][4];

  typedef struct {
    logic [7:0]  addr;
    logic        sel;
    logic [31:0] exp;
    string       nm;
  } rd_vec_t;

  rd_vec_t tbl [7];

  sweep_scheduler #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(1000)) dut (
    .clk125(clk125), .areset_n(areset_n), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .num_points(num_points), .avg_log2(avg_log2), .mp_start(mp_start), .mp_fin(mp_fin),
    .valid_m(valid_m), .modulo(modulo), .valid_p(valid_p), .phase(phase),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_overflow(err_overflow), .sweep_idx(sweep_idx)
  );

  always #4 clk125 = ~clk125;

  task automatic tick();
    @(posedge clk125);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", nm, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  task automatic wait_mp(input logic val);
    int n = 0;
    while (mp_start !== val && n < 100) begin
      tick();
      n++;
    end
    chk("wait_mp_start", {31'd0, mp_start}, {31'd0, val});
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_start(input int np, input int avg);
    num_points = 8'(np);
    avg_log2   = 2'(avg);
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
  endtask

  task automatic do_sweep(input int s, input int n);
    wait_mp(1'b1);
    chk($sformatf("sweep_idx_%0d", s), {29'd0, sweep_idx}, 32'(s));
    tick();
    for (int i = 0; i < n; i++) begin
      valid_m = 1'b1; modulo = m_tab[s][i];
      valid_p = 1'b1; phase  = p_tab[s][i];
      tick();
    end
    valid_m = 1'b0; valid_p = 1'b0;
    mp_fin = 1'b1;
    tick();
    wait_mp(1'b0);
    mp_fin = 1'b0;
    tick();
  endtask

  task automatic rd(input string nm, input int addr, input logic sel, input logic [31:0] exp);
    rd_addr = 8'(addr);
    rd_sel  = sel;
    tick();
    chk(nm, rd_data, exp);
  endtask

  initial begin
    areset_n = 1'b0; cmd_start = 0; cmd_abort = 0; num_points = 0; avg_log2 = 0;
    mp_fin = 0; valid_m = 0; valid_p = 0; modulo = 0; phase = 0; rd_addr = 0; rd_sel = 0;
    #20;
    chk("rst_mp_start", {31'd0, mp_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_errs", {30'd0, err_timeout, err_overflow}, 32'd0);
    chk("rst_sweep_idx", {29'd0, sweep_idx}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    tick();
    areset_n = 1'b1;
    tick();

    // num_points = 0 must not start a run
    pulse_start(0, 0);
    tick();
    chk("np0_busy", {31'd0, busy}, 32'd0);
    chk("np0_mp_start", {31'd0, mp_start}, 32'd0);

    // Test 1: three points, single sweep
    m_tab[0][0] = 100; m_tab[0][1] = 200; m_tab[0][2] = 300;
    p_tab[0][0] = -5;  p_tab[0][1] = 0;   p_tab[0][2] = 7;
    tbl[0] = '{8'd0, 1'b0, 32'd100, "t1_m0"};
    tbl[1] = '{8'd1, 1'b0, 32'd200, "t1_m1"};
    tbl[2] = '{8'd2, 1'b0, 32'd300, "t1_m2"};
    tbl[3] = '{8'd0, 1'b1, -32'sd5, "t1_p0"};
    tbl[4] = '{8'd1, 1'b1, 32'd0,   "t1_p1"};
    tbl[5] = '{8'd2, 1'b1, 32'd7,   "t1_p2"};
    tbl[6] = '{8'd3, 1'b0, 32'd0,   "t1_oob"};
    pulse_start(3, 0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    do_sweep(0, 3);
    wait_done();
    chk("t1_mp_start", {31'd0, mp_start}, 32'd0);
    chk("t1_busy_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 7; i++) rd(tbl[i].nm, int'(tbl[i].addr), tbl[i].sel, tbl[i].exp);

    // Test 2: four sweeps averaged, one point
    for (int s = 0; s < 4; s++) begin
      m_tab[s][0] = 10 + s;
      p_tab[s][0] = -1 - s;
    end
    pulse_start(1, 2);
    chk("t2_done_cleared", {31'd0, done}, 32'd0);
    for (int s = 0; s < 4; s++) do_sweep(s, 1);
    wait_done();
    rd("t2_avg_m", 0, 1'b0, 32'd11);
    rd("t2_avg_p", 0, 1'b1, -32'sd3);

    // Test 3: simultaneous strobes, last phase 20 cycles after mp_fin
    pulse_start(2, 0);
    wait_mp(1'b1);
    tick();
    valid_m = 1; modulo = 40; valid_p = 1; phase = -9;
    tick();
    valid_p = 0; modulo = 50;
    tick();
    valid_m = 0; mp_fin = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("t3_drain_mp_start", {31'd0, mp_start}, 32'd1);
    chk("t3_drain_busy", {31'd0, busy}, 32'd1);
    valid_p = 1; phase = 9;
    tick();
    valid_p = 0;
    wait_mp(1'b0);
    mp_fin = 0;
    tick();
    wait_done();
    rd("t3_m0", 0, 1'b0, 32'd40);
    rd("t3_m1", 1, 1'b0, 32'd50);
    rd("t3_p0", 0, 1'b1, -32'sd9);
    rd("t3_p1", 1, 1'b1, 32'd9);
    chk("t3_no_ovf", {31'd0, err_overflow}, 32'd0);

    // Test 6: overflow on third magnitude strobe
    pulse_start(2, 0);
    wait_mp(1'b1);
    tick();
    valid_m = 1; modulo = 5; valid_p = 1; phase = 1;
    tick();
    modulo = 6; phase = 2;
    tick();
    valid_p = 0; modulo = 7;
    tick();
    valid_m = 0;
    chk("t6_err_overflow", {31'd0, err_overflow}, 32'd1);
    mp_fin = 1;
    tick();
    wait_mp(1'b0);
    mp_fin = 0;
    tick();
    wait_done();
    rd("t6_m0", 0, 1'b0, 32'd5);
    rd("t6_m1", 1, 1'b0, 32'd6);
    rd("t6_oob", 2, 1'b0, 32'd0);

    // Test 5: abort mid-run, then start+abort together
    pulse_start(2, 0);
    chk("t5_ovf_cleared", {31'd0, err_overflow}, 32'd0);
    wait_mp(1'b1);
    tick(); tick(); tick();
    cmd_abort = 1;
    tick();
    cmd_abort = 0;
    chk("t5_abort_mp_start", {31'd0, mp_start}, 32'd0);
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_abort_done", {31'd0, done}, 32'd0);
    num_points = 2; cmd_start = 1; cmd_abort = 1;
    tick();
    cmd_start = 0; cmd_abort = 0;
    chk("t5_both_mp_start", {31'd0, mp_start}, 32'd0);
    tick(); tick(); tick();
    chk("t5_both_busy", {31'd0, busy}, 32'd0);

    // Test 4: watchdog with no strobes
    pulse_start(1, 0);
    for (int i = 0; i < 900; i++) tick();
    chk("t4_early_err", {31'd0, err_timeout}, 32'd0);
    chk("t4_early_busy", {31'd0, busy}, 32'd1);
    begin
      int n = 0;
      while (err_timeout !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
    end
    chk("t4_err_timeout", {31'd0, err_timeout}, 32'd1);
    chk("t4_mp_start", {31'd0, mp_start}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    tick(); tick();
    chk("t4_sticky", {31'd0, err_timeout}, 32'd1);
    pulse_start(1, 0);
    chk("t4_restart_clears", {31'd0, err_timeout}, 32'd0);
    chk("t4_restart_busy", {31'd0, busy}, 32'd1);
    cmd_abort = 1;
    tick();
    cmd_abort = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
